// File: rtl/puc_pkg.sv
// puc_pkg: shared widths, opcodes and the default boot image for the PUC CPU.
// Used by the ALU/memory helper and the CPU control logic.
package puc_pkg;

    localparam int REGISTER_WIDTH    = 16;
    localparam int PC_WIDTH          = 4;
    localparam int INSTRUCTION_WIDTH = 16;
    localparam int OPCODE_WIDTH      = 4;
    localparam int MEM_DEPTH         = 2 ** PC_WIDTH;

    typedef enum logic [OPCODE_WIDTH-1:0] {
        OP_LOAD0       = 4'd0,
        OP_MOVE1       = 4'd1,
        OP_ADD2        = 4'd2,
        OP_JUMP3       = 4'd3,
        OP_RESET4      = 4'd4,
        OP_IF0JUMP5    = 4'd5,
        OP_IF1JUMP6    = 4'd6,
        OP_LOADSWITCH7 = 4'd7,
        OP_CALL8       = 4'd8,
        OP_EXIT9       = 4'd9,
        OP_LOADREG10   = 4'd10,
        OP_INCREMENT11 = 4'd11,
        OP_COPY12      = 4'd12
    } opcode_e;

    // r0=5, r1=3, r1=r0+r1, poll switch, call increment routine at 0xC
    localparam logic [INSTRUCTION_WIDTH-1:0] BOOT_IMAGE [MEM_DEPTH] = '{
        16'h0005, 16'h1000, 16'h0003, 16'h1100,
        16'h2000, 16'h1100, 16'h7000, 16'h600A,
        16'h3006, 16'h3000, 16'h800C, 16'h3006,
        16'hB000, 16'h9000, 16'h3000, 16'h3000
    };

    function automatic logic [INSTRUCTION_WIDTH-1:0] boot_word(
        input logic [PC_WIDTH-1:0] addr
    );
        return BOOT_IMAGE[addr];
    endfunction

endpackage

// File: rtl/puc_alu_mem_if.sv
// puc_alu_mem_if: CPU <-> ALU/program-memory bus.
// master = CPU side, slave = puc_alu_mem. prog* exist only with PUC_PROG_LOAD_EN.
interface puc_alu_mem_if;
    import puc_pkg::*;

    logic [PC_WIDTH-1:0]          pc;
    logic [INSTRUCTION_WIDTH-1:0] instruction;
    logic [REGISTER_WIDTH-1:0]    accumulator;
    logic [REGISTER_WIDTH-1:0]    register0Value;
    logic [REGISTER_WIDTH-1:0]    register1Value;
    logic [OPCODE_WIDTH-1:0]      opCode;
    logic [REGISTER_WIDTH-1:0]    aluResult;
`ifdef PUC_PROG_LOAD_EN
    logic                         progWrite;
    logic [PC_WIDTH-1:0]          progAddr;
    logic [INSTRUCTION_WIDTH-1:0] progData;

    modport master (
        output pc, accumulator, register0Value, register1Value, opCode,
        output progWrite, progAddr, progData,
        input  instruction, aluResult
    );
    modport slave (
        input  pc, accumulator, register0Value, register1Value, opCode,
        input  progWrite, progAddr, progData,
        output instruction, aluResult
    );
`else
    modport master (
        output pc, accumulator, register0Value, register1Value, opCode,
        input  instruction, aluResult
    );
    modport slave (
        input  pc, accumulator, register0Value, register1Value, opCode,
        output instruction, aluResult
    );
`endif

endinterface

// File: rtl/puc_alu.sv
// puc_alu: zero-latency PUC ALU. ADD2 -> r0+r1, INCREMENT11 -> acc+1,
// all others -> acc. Ports: i_opCode, i_accumulator, i_reg0, i_reg1, o_result.
module puc_alu
    import puc_pkg::*;
(
    input  logic [OPCODE_WIDTH-1:0]   i_opCode,
    input  logic [REGISTER_WIDTH-1:0] i_accumulator,
    input  logic [REGISTER_WIDTH-1:0] i_reg0,
    input  logic [REGISTER_WIDTH-1:0] i_reg1,
    output logic [REGISTER_WIDTH-1:0] o_result
);

    localparam logic [REGISTER_WIDTH-1:0] ONE = REGISTER_WIDTH'(1);

    always_comb begin
        o_result = i_accumulator;
        case (i_opCode)
            OP_ADD2:        o_result = i_reg0 + i_reg1;
            OP_INCREMENT11: o_result = i_accumulator + ONE;
            default:        o_result = i_accumulator;
        endcase
    end

endmodule

// File: rtl/puc_alu_mem.sv
// puc_alu_mem: 16-word program memory (read by pc) plus the PUC ALU.
// Ports: clock, isReset (sync, active high), bus (puc_alu_mem_if.slave).
// PUC_PROG_LOAD_EN: RAM with write port, reset reloads boot image;
// otherwise a constant ROM and clock/isReset are unused.
module puc_alu_mem
    import puc_pkg::*;
(
    input  logic          clock,
    input  logic          isReset,
    puc_alu_mem_if.slave  bus
);

    puc_alu u_alu (
        .i_opCode      (bus.opCode),
        .i_accumulator (bus.accumulator),
        .i_reg0        (bus.register0Value),
        .i_reg1        (bus.register1Value),
        .o_result      (bus.aluResult)
    );

`ifdef PUC_PROG_LOAD_EN
    logic [INSTRUCTION_WIDTH-1:0] r_mem [MEM_DEPTH];

    // reset wins over a same-edge write
    always_ff @(posedge clock) begin
        if (isReset) begin
            for (int i = 0; i < MEM_DEPTH; i++) begin
                r_mem[i] <= BOOT_IMAGE[i];
            end
        end else if (bus.progWrite) begin
            r_mem[bus.progAddr] <= bus.progData;
        end
    end

    assign bus.instruction = r_mem[bus.pc];
`else
    // ROM build has no state; keep clock/isReset as ports for the CPU
    logic w_unused;
    assign w_unused = &{1'b0, clock, isReset};

    assign bus.instruction = boot_word(bus.pc);
`endif

endmodule

// File: tb/tb_puc_alu_mem.sv
// tb_puc_alu_mem: directed vectors plus a per-cycle reference model
// of the program memory and ALU for puc_alu_mem.
module tb_puc_alu_mem;

    logic clock = 1'b0;
    logic isReset;
    int   total = 0;
    int   bad   = 0;
    bit   chk_en = 1'b0;

    always #5 clock = ~clock;

    puc_alu_mem_if bus ();

    puc_alu_mem dut (
        .clock   (clock),
        .isReset (isReset),
        .bus     (bus)
    );

    logic [15:0] image_m [16] = '{
        16'h0005, 16'h1000, 16'h0003, 16'h1100,
        16'h2000, 16'h1100, 16'h7000, 16'h600A,
        16'h3006, 16'h3000, 16'h800C, 16'h3006,
        16'hB000, 16'h9000, 16'h3000, 16'h3000
    };
    logic [15:0] mem_m [16];

    initial mem_m = image_m;

    function automatic logic [15:0] alu_model(
        input int op, input int acc, input int r0, input int r1
    );
        int v;
        if (op == 2)       v = (r0 + r1) % 65536;
        else if (op == 11) v = (acc + 1) % 65536;
        else               v = acc;
        return 16'(v);
    endfunction

    task automatic check(
        input string nm, input logic [15:0] got, input logic [15:0] exp
    );
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h t=%0t", nm, got, exp, $time);
        end
    endtask

    // reference memory: reset reloads image, otherwise a write lands
    always @(posedge clock) begin
        if (isReset) mem_m = image_m;
`ifdef PUC_PROG_LOAD_EN
        else if (bus.progWrite) mem_m[bus.progAddr] = bus.progData;
`endif
    end

    always @(negedge clock) begin
        if (chk_en) begin
            check("model_instr", bus.instruction, mem_m[bus.pc]);
            check("model_alu", bus.aluResult,
                  alu_model(int'(bus.opCode), int'(bus.accumulator),
                            int'(bus.register0Value),
                            int'(bus.register1Value)));
        end
    end

    typedef struct {
        logic [3:0]  op;
        logic [15:0] acc;
        logic [15:0] r0;
        logic [15:0] r1;
        logic [15:0] exp;
    } alu_vec_t;

    alu_vec_t vecs [9] = '{
        '{4'd2,  16'h0000, 16'h0005, 16'h0003, 16'h0008},
        '{4'd2,  16'h0000, 16'hFFFF, 16'h0002, 16'h0001},
        '{4'd11, 16'h0007, 16'h0000, 16'h0000, 16'h0008},
        '{4'd11, 16'hFFFF, 16'h0000, 16'h0000, 16'h0000},
        '{4'd0,  16'h1234, 16'h0005, 16'h0003, 16'h1234},
        '{4'd7,  16'h1234, 16'h0005, 16'h0003, 16'h1234},
        '{4'd13, 16'h1234, 16'h0005, 16'h0003, 16'h1234},
        '{4'd12, 16'hABCD, 16'h1111, 16'h2222, 16'hABCD},
        '{4'd15, 16'h00FF, 16'h8000, 16'h8000, 16'h00FF}
    };

    task automatic step();
        @(posedge clock);
        #2;
    endtask

    initial begin
        isReset                = 1'b1;
        bus.pc                 = '0;
        bus.accumulator        = '0;
        bus.register0Value     = '0;
        bus.register1Value     = '0;
        bus.opCode             = '0;
`ifdef PUC_PROG_LOAD_EN
        bus.progWrite          = 1'b0;
        bus.progAddr           = '0;
        bus.progData           = '0;
`endif
        step();
        chk_en = 1'b1;
        @(negedge clock);
        check("reset_pc0", bus.instruction, 16'h0005);
        step();
        isReset = 1'b0;

        for (int i = 0; i < 16; i++) begin
            bus.pc = 4'(i);
            @(negedge clock);
            check("sweep", bus.instruction, image_m[i]);
            step();
        end
        bus.pc = 4'd4;
        @(negedge clock);
        check("pc4", bus.instruction, 16'h2000);
        step();
        bus.pc = 4'd10;
        @(negedge clock);
        check("pc10", bus.instruction, 16'h800C);
        step();

        for (int i = 0; i < 9; i++) begin
            bus.opCode         = vecs[i].op;
            bus.accumulator    = vecs[i].acc;
            bus.register0Value = vecs[i].r0;
            bus.register1Value = vecs[i].r1;
            @(negedge clock);
            check("alu_vec", bus.aluResult, vecs[i].exp);
            step();
        end

`ifdef PUC_PROG_LOAD_EN
        bus.pc        = 4'd3;
        bus.progWrite = 1'b1;
        bus.progAddr  = 4'd3;
        bus.progData  = 16'hBEEF;
        @(negedge clock);
        check("wr_before", bus.instruction, 16'h1100);
        step();
        bus.progWrite = 1'b0;
        @(negedge clock);
        check("wr_after", bus.instruction, 16'hBEEF);
        bus.pc = 4'd2;
        @(negedge clock);
        check("wr_neighbour", bus.instruction, 16'h0003);
        step();

        isReset = 1'b1;
        bus.pc  = 4'd3;
        step();
        isReset = 1'b0;
        @(negedge clock);
        check("rst_restore", bus.instruction, 16'h1100);
        step();

        isReset       = 1'b1;
        bus.progWrite = 1'b1;
        bus.progAddr  = 4'd0;
        bus.progData  = 16'hFFFF;
        step();
        isReset       = 1'b0;
        bus.progWrite = 1'b0;
        bus.pc        = 4'd0;
        @(negedge clock);
        check("rst_over_wr", bus.instruction, 16'h0005);
        step();
`endif

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
